// File: rtl/fetch_unit.sv
`default_nettype none
// fetch_unit: holds the PC, requests instruction memory and presents each fetched word to decode.
// A taken branch redirects the PC; a wrong-path request still in flight is drained in FLUSH.
module fetch_unit #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_pc,
  input  logic [23:0]       branch_imm,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  input  logic              imem_valid,
  output logic [31:0]       instruction,
  output logic              instr_valid,
  output logic [ADDR_W-1:0] instr_pc
);

  localparam logic [1:0] S_REQ   = 2'd0;
  localparam logic [1:0] S_HOLD  = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] flush_addr_q, flush_addr_d;
  logic [31:0]       instr_q, instr_d;
  logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;
  logic              valid_q, valid_d;

  logic [ADDR_W-1:0] offset_w;
  logic [ADDR_W-1:0] target_w;

  // Word offset scaled to bytes; sign bits beyond the PC width are irrelevant modulo 2^ADDR_W.
  generate
    if (ADDR_W > 26) begin : g_off_wide
      assign offset_w = {{(ADDR_W-26){branch_imm[23]}}, branch_imm, 2'b00};
    end else begin : g_off_narrow
      assign offset_w = {branch_imm[ADDR_W-3:0], 2'b00};
    end
  endgenerate

  assign target_w = branch_pc + ADDR_W'(8) + offset_w;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_REQ;
      pc_q         <= RESET_PC;
      flush_addr_q <= '0;
      instr_q      <= '0;
      instr_pc_q   <= '0;
      valid_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      flush_addr_q <= flush_addr_d;
      instr_q      <= instr_d;
      instr_pc_q   <= instr_pc_d;
      valid_q      <= valid_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    flush_addr_d = flush_addr_q;
    instr_d      = instr_q;
    instr_pc_d   = instr_pc_q;
    valid_d      = valid_q;
    if (branch_taken) begin
      pc_d    = target_w;
      valid_d = 1'b0;
      case (state_q)
        S_REQ: begin
          // An unanswered request cannot be withdrawn, so its address is kept until it completes.
          if (!imem_valid) begin
            flush_addr_d = pc_q;
            state_d      = S_FLUSH;
          end
        end
        S_FLUSH: begin
          if (imem_valid) state_d = S_REQ;
        end
        default: state_d = S_REQ;
      endcase
    end else begin
      case (state_q)
        S_REQ: begin
          if (imem_valid) begin
            instr_d    = imem_rdata;
            instr_pc_d = pc_q;
            valid_d    = 1'b1;
            pc_d       = pc_q + ADDR_W'(4);
            state_d    = S_HOLD;
          end
        end
        S_HOLD: begin
          if (!stall) begin
            valid_d = 1'b0;
            state_d = S_REQ;
          end
        end
        S_FLUSH: begin
          if (imem_valid) state_d = S_REQ;
        end
        default: state_d = S_REQ;
      endcase
    end
  end

  always_comb begin
    imem_req  = 1'b0;
    imem_addr = pc_q;
    case (state_q)
      S_REQ:   imem_req = rst;
      S_FLUSH: begin
        imem_req  = rst;
        imem_addr = flush_addr_q;
      end
      default: imem_req = 1'b0;
    endcase
  end

  assign instruction = instr_q;
  assign instr_valid = valid_q;
  assign instr_pc    = instr_pc_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
`timescale 1ns/1ps
// tb_fetch_unit: random memory latency, stalls and branches against a program-order reference
// of which PCs must reach decode; a separate monitor pops expectations when words are presented.
module tb_fetch_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, stall, branch_taken;
  logic [31:0] branch_pc;
  logic [23:0] branch_imm;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = '0;
  logic        imem_valid = 1'b0;
  logic [31:0] instruction;
  logic        instr_valid;
  logic [31:0] instr_pc;

  fetch_unit #(.ADDR_W(32), .RESET_PC(32'h0)) u_dut (
    .clk(clk), .rst(rst), .stall(stall), .branch_taken(branch_taken),
    .branch_pc(branch_pc), .branch_imm(branch_imm),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_valid(imem_valid),
    .instruction(instruction), .instr_valid(instr_valid), .instr_pc(instr_pc)
  );

  // Narrow instance for PC wrap-around at ADDR_W=8.
  logic        rst8, stall8, br8;
  logic [7:0]  bpc8;
  logic [23:0] bimm8;
  logic        req8;
  logic [7:0]  addr8;
  logic [31:0] rdata8 = 32'h1234_5678;
  logic        valid8 = 1'b1;
  logic [31:0] instr8;
  logic        iv8;
  logic [7:0]  ipc8;

  fetch_unit #(.ADDR_W(8), .RESET_PC(8'h0)) u_dut8 (
    .clk(clk), .rst(rst8), .stall(stall8), .branch_taken(br8),
    .branch_pc(bpc8), .branch_imm(bimm8),
    .imem_req(req8), .imem_addr(addr8), .imem_rdata(rdata8), .imem_valid(valid8),
    .instruction(instr8), .instr_valid(iv8), .instr_pc(ipc8)
  );

  int n_checks  = 0;
  int n_fail    = 0;
  int n_present = 0;
  int force_lat = 0;
  logic [31:0] exp_q[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E3779B9) ^ 32'hE0810002;
  endfunction

  function automatic logic [31:0] br_target(input logic [31:0] pc, input logic [23:0] imm);
    return pc + 32'd8 + 32'(int'($signed(imm)) * 4);
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Instruction memory: random or forced latency, answers the address captured at request start.
  logic        pending = 1'b0;
  logic [31:0] paddr = '0;
  int          lat = 0;
  always @(negedge clk) begin
    if (!rst) begin
      pending    = 1'b0;
      imem_valid = 1'b0;
      imem_rdata = '0;
    end else if (imem_req) begin
      if (!pending) begin
        pending = 1'b1;
        paddr   = imem_addr;
        lat     = (force_lat >= 0) ? force_lat : int'($urandom_range(0, 3));
      end else begin
        check("addr_stable", imem_addr, paddr);
      end
      if (lat == 0) begin
        imem_valid = 1'b1;
        imem_rdata = mem_word(paddr);
        pending    = 1'b0;
      end else begin
        lat--;
        imem_valid = 1'b0;
        imem_rdata = $urandom;
      end
    end else begin
      check("req_withdrawn", {63'd0, pending}, 64'd0);
      imem_valid = 1'($urandom_range(0, 1));
      imem_rdata = $urandom;
    end
  end

  // Monitor: each new presentation must be the next PC in program order.
  logic        prev_valid = 1'b0, prev_stall = 1'b0, prev_br = 1'b0;
  logic [31:0] hold_pc = '0, hold_instr = '0, exp_pc = '0;
  always @(negedge clk) begin
    if (!rst) begin
      prev_valid = 1'b0;
      prev_stall = 1'b0;
      prev_br    = 1'b0;
    end else begin
      if (prev_valid)   check("valid_after_hold", instr_valid, prev_stall && !prev_br);
      else if (prev_br) check("no_present_on_branch", instr_valid, 0);
      if (instr_valid && prev_valid) begin
        check("hold_pc", instr_pc, hold_pc);
        check("hold_instr", instruction, hold_instr);
      end else if (instr_valid) begin
        if (exp_q.size() > 0) begin
          exp_pc = exp_q[$];
          exp_q.delete();
        end
        check("present_pc", instr_pc, exp_pc);
        check("present_instr", instruction, mem_word(exp_pc));
        exp_pc = exp_pc + 32'd4;
        n_present++;
      end
      hold_pc    = instr_pc;
      hold_instr = instruction;
      prev_valid = instr_valid;
      prev_stall = stall;
      prev_br    = branch_taken;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_branch(input logic [31:0] pc, input logic [23:0] imm);
    branch_taken = 1'b1;
    branch_pc    = pc;
    branch_imm   = imm;
    tick();
    branch_taken = 1'b0;
    exp_q.push_back(br_target(pc, imm));
  endtask

  task automatic test_addr8();
    @(posedge clk); #3;
    rst8 = 1'b1; br8 = 1'b1; bpc8 = 8'hF0; bimm8 = 24'h1;
    @(posedge clk); #2;
    br8 = 1'b0;
    check("a8_branch_addr", addr8, 8'hFC);
    check("a8_branch_req", req8, 1);
    @(posedge clk); #2;
    check("a8_valid", iv8, 1);
    check("a8_pc", ipc8, 8'hFC);
    check("a8_instr", instr8, 32'h1234_5678);
    @(posedge clk); #2;
    check("a8_wrap_req", req8, 1);
    check("a8_wrap_addr", addr8, 8'h00);
    br8 = 1'b1; bpc8 = 8'hF8; bimm8 = 24'h1;
    @(posedge clk); #2;
    br8 = 1'b0;
    check("a8_target_wrap", addr8, 8'h04);
  endtask

  logic [31:0] rnd_pc;
  logic [23:0] rnd_imm;
  int          waited;

  initial begin
    rst = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_pc = '0; branch_imm = '0;
    rst8 = 1'b0; stall8 = 1'b0; br8 = 1'b0; bpc8 = '0; bimm8 = '0;
    force_lat = 0;
    exp_q.push_back(32'h0);
    #1;
    check("rst_req", imem_req, 0);
    check("rst_valid", instr_valid, 0);
    check("rst_instr", instruction, 0);
    check("rst_pc", instr_pc, 0);

    // First fetch at RESET_PC, then hold under stall.
    @(posedge clk); @(posedge clk); #3;
    rst = 1'b1;
    #1;
    check("t1_req", imem_req, 1);
    check("t1_addr", imem_addr, 32'h0);
    stall = 1'b1;
    tick();
    check("t1_instr", instruction, 32'hE0810002);
    check("t1_valid", instr_valid, 1);
    check("t1_pc", instr_pc, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t2_stall_valid", instr_valid, 1);
      check("t2_stall_pc", instr_pc, 32'h0);
      check("t2_stall_req", imem_req, 0);
    end
    stall = 1'b0;
    tick();
    check("t2_next_req", imem_req, 1);
    check("t2_next_addr", imem_addr, 32'h4);

    // Branch targets forward and backward, both overriding a completing fetch.
    do_branch(32'h10, 24'h000002);
    check("t3_fwd_addr", imem_addr, 32'h20);
    check("t3_fwd_valid", instr_valid, 0);
    do_branch(32'h10, 24'hFFFFFE);
    check("t3_back_addr", imem_addr, 32'h10);
    check("t3_back_valid", instr_valid, 0);

    // Branch while a slow request to 0x8 is outstanding.
    do_branch(32'h0, 24'h0);
    force_lat = 3;
    check("t4_req_addr", imem_addr, 32'h8);
    tick();
    do_branch(32'h30, 24'h000002);
    waited = 0;
    while (imem_addr == 32'h8 && waited < 8) begin
      check("t4_flush_req", imem_req, 1);
      check("t4_flush_valid", instr_valid, 0);
      tick();
      waited++;
    end
    check("t4_next_addr", imem_addr, 32'h40);
    check("t4_next_req", imem_req, 1);

    // Asynchronous reset in the middle of a wait.
    tick();
    #1;
    rst = 1'b0;
    exp_q.delete();
    exp_q.push_back(32'h0);
    #1;
    check("t5_async_req", imem_req, 0);
    check("t5_async_valid", instr_valid, 0);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    check("t5_release_req", imem_req, 1);
    check("t5_release_addr", imem_addr, 32'h0);
    force_lat = -1;

    // 32-bit wrap: FFFFFFFC is followed by 0.
    tick();
    do_branch(32'hFFFF_FFF0, 24'h000001);
    for (int i = 0; i < 20; i++) tick();

    for (int i = 0; i < 3000; i++) begin
      stall = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 9) == 0) begin
        rnd_pc  = $urandom;
        rnd_imm = $urandom;
        if ($urandom_range(0, 1) == 1) rnd_imm = 24'($urandom_range(0, 31)) - 24'd16;
        do_branch(rnd_pc, rnd_imm);
      end else begin
        tick();
      end
    end
    stall = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    check("throughput", {63'd0, (n_present > 300)}, 64'd1);

    test_addr8();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage directly upstream of the decode stage.
- Holds the PC and issues requests to instruction memory through a request/valid handshake.
- Registers the fetched word and presents it, with its PC, to decode.
- Applies stalls from downstream and redirects the PC on a taken branch, discarding any wrong-path fetch still in flight.

Parameters:
ADDR_W, 32, width of PC and instruction-memory address.
RESET_PC, 0, PC value loaded on reset.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous active-low reset.
stall  input  1  downstream cannot accept; hold the presented instruction.
branch_taken  input  1  one-cycle pulse: redirect PC.
branch_pc  input  ADDR_W  PC of the branch instruction.
branch_imm  input  24  signed word offset, instruction[23:0] of the branch.
imem_req  output  1  instruction-memory request.
imem_addr  output  ADDR_W  request address; stable while imem_req=1.
imem_rdata  input  32  returned instruction word.
imem_valid  input  1  imem_rdata valid this cycle; only meaningful while imem_req=1.
instruction  output  32  registered instruction to decode.
instr_valid  output  1  instruction holds a valid, not-yet-consumed word.
instr_pc  output  ADDR_W  PC of the presented instruction.

Behaviour:
- Reset (rst=0, asynchronous, any state):
  - pc=RESET_PC; state=REQ; instruction=0; instr_valid=0; instr_pc=0.
  - imem_req deasserts immediately.
  - After release, REQ issues at RESET_PC.
- Outputs:
  - imem_req=1 only in REQ and FLUSH.
  - In REQ, imem_addr=pc. In FLUSH, imem_addr=flush_addr, the address of the abandoned request, held stable.
  - All other outputs are registered.
- Request rule: once raised, imem_req stays high with a constant address until a cycle with imem_valid=1. A request is never withdrawn; it is only completed or flushed.
- State REQ, imem_valid=1 at the edge:
  - instruction<=imem_rdata; instr_pc<=pc; instr_valid<=1; pc<=pc+4 (mod 2^ADDR_W); state<=HOLD.
- State REQ, imem_valid=0: stay in REQ.
- State HOLD:
  - imem_req=0; instr_valid=1.
  - stall=0: entry consumed; instr_valid<=0; state<=REQ.
  - stall=1: instruction, instr_pc and pc all frozen.
- Throughput: with zero-wait memory, one instruction per 2 cycles (REQ, HOLD).
- Branch target: branch_pc + 8 + (sign_extend(branch_imm) << 2), truncated to ADDR_W.
- branch_taken=1 at an edge overrides every other event except reset:
  - pc<=target; instr_valid<=0; instruction and instr_pc retain their old values (ignored while instr_valid=0).
  - From HOLD: state<=REQ; the stall value is irrelevant.
  - From REQ with imem_valid=1 the same cycle: the returned word is discarded; state<=REQ; the next cycle requests target.
  - From REQ with imem_valid=0: flush_addr<=old pc; state<=FLUSH.
- State FLUSH:
  - On imem_valid=1: data discarded; state<=REQ.
  - A further branch_taken while in FLUSH updates pc to the new target and stays in FLUSH.
  - instr_valid=0 throughout.
- stall arriving while instr_valid=0 has no effect; fetching continues.
- branch_taken and stall asserted together: the branch wins.
- PC increment and target arithmetic wrap modulo 2^ADDR_W; no error is flagged.

Test Plan:
1. Reset release, zero-wait memory returns 0xE0810002 at addr 0 -> cycle 1: imem_req=1, imem_addr=0x0. Next cycle: instruction=0xE0810002, instr_valid=1, instr_pc=0x0. Following cycle: imem_addr=0x4.
2. stall=1 for 3 cycles while in HOLD -> instruction, instr_pc=0x0 and instr_valid=1 constant; imem_req=0. After stall drops, one REQ at 0x4.
3. branch_taken with branch_pc=0x10, branch_imm=0x000002 -> next imem_addr=0x20, instr_valid=0. Repeat with branch_imm=0xFFFFFE -> imem_addr=0x10.
4. Memory with 3-cycle latency; branch_taken (target 0x40) one cycle after request to 0x8 -> imem_addr stays 0x8 until imem_valid; that word is never presented (instr_valid stays 0); next request at 0x40.
5. rst=0 asserted mid-wait on a request -> outputs clear asynchronously (imem_req=0, instr_valid=0). After release: imem_req=1, imem_addr=RESET_PC.
6. ADDR_W=8, PC at 0xFC, fetch completes -> next imem_addr=0x00. Branch with branch_pc=0xF8, branch_imm=0x000001 -> target 0x04.
